// File: rtl/pattern_mapper.sv
// LE Coded pattern mapper: spreads each FEC-encoded bit into 4 chips (S=8) or forwards
// it unchanged (S=2), with a 1-bit AXI-Stream style handshake on both sides.
package pattern_mapper_pkg;
    typedef enum logic {
        CI_S8 = 1'b0,
        CI_S2 = 1'b1
    } ble_ci_t;
endpackage

module pattern_mapper
    import pattern_mapper_pkg::*;
(
    input  logic    aclk,
    input  logic    areset,
    input  logic    restart,
    input  logic    bypass,
    input  ble_ci_t coding_indicator,
    input  logic    input_tdata,
    input  logic    input_tvalid,
    output logic    input_tready,
    input  logic    input_tlast,
    output logic    output_tdata,
    output logic    output_tvalid,
    input  logic    output_tready,
    output logic    output_tlast
);

    logic       bit_q;
    logic       last_q;
    logic [1:0] idx_q;
    logic       valid_q;
    ble_ci_t    ci_q;
    logic       pkt_open_q;

    logic last_idx;
    logic chip_done;
    logic core_ready;
    logic accept;
    logic chip_data;

    // S8 pattern: bit,bit,~bit,~bit, so the upper half of the index inverts the chip.
    assign last_idx   = (ci_q == CI_S2) || (idx_q == 2'd3);
    assign chip_done  = output_tready && valid_q && last_idx;
    assign core_ready = !restart && (!valid_q || chip_done);
    assign accept     = !bypass && input_tvalid && core_ready;
    assign chip_data  = bit_q ^ ((ci_q == CI_S8) && idx_q[1]);

    always_comb begin
        if (bypass) begin
            output_tdata  = input_tdata;
            output_tvalid = input_tvalid;
            output_tlast  = input_tlast;
            input_tready  = output_tready;
        end else begin
            output_tdata  = chip_data;
            output_tvalid = valid_q;
            output_tlast  = valid_q && last_q && last_idx;
            input_tready  = core_ready;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bit_q      <= 1'b0;
            last_q     <= 1'b0;
            idx_q      <= 2'd0;
            valid_q    <= 1'b0;
            ci_q       <= CI_S8;
            pkt_open_q <= 1'b0;
        end else if (restart) begin
            bit_q      <= 1'b0;
            last_q     <= 1'b0;
            idx_q      <= 2'd0;
            valid_q    <= 1'b0;
            ci_q       <= CI_S8;
            pkt_open_q <= 1'b0;
        end else if (!bypass) begin
            if (accept) begin
                bit_q      <= input_tdata;
                last_q     <= input_tlast;
                idx_q      <= 2'd0;
                valid_q    <= 1'b1;
                pkt_open_q <= 1'b1;
                // A new packet starts either from idle or right as the previous tlast chip leaves.
                if (!pkt_open_q || (chip_done && last_q)) begin
                    ci_q <= coding_indicator;
                end
            end else if (chip_done) begin
                valid_q <= 1'b0;
                if (last_q) begin
                    pkt_open_q <= 1'b0;
                end
            end else if (output_tready && valid_q) begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_mapper.sv
// Self-checking bench for pattern_mapper: randomized streams compared against a
// packet-level chip model (each accepted bit expands to its chip list).
module tb_pattern_mapper;
    import pattern_mapper_pkg::*;

    logic    aclk = 1'b0;
    logic    areset;
    logic    restart;
    logic    bypass;
    ble_ci_t coding_indicator;
    logic    input_tdata;
    logic    input_tvalid;
    logic    input_tready;
    logic    input_tlast;
    logic    output_tdata;
    logic    output_tvalid;
    logic    output_tready;
    logic    output_tlast;

    pattern_mapper dut (
        .aclk             (aclk),
        .areset           (areset),
        .restart          (restart),
        .bypass           (bypass),
        .coding_indicator (coding_indicator),
        .input_tdata      (input_tdata),
        .input_tvalid     (input_tvalid),
        .input_tready     (input_tready),
        .input_tlast      (input_tlast),
        .output_tdata     (output_tdata),
        .output_tvalid    (output_tvalid),
        .output_tready    (output_tready),
        .output_tlast     (output_tlast)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_q[$];   // {chip, last} expected in emission order
    logic [1:0] got_q[$];   // {chip, last} actually transferred
    int         got_cyc[$];
    logic       rdy_log[$];
    logic       fb[$];
    logic       fl[$];
    ble_ci_t    fc[$];

    logic    m_open = 1'b0;
    ble_ci_t m_ci   = CI_S8;

    logic o_rdy, o_val, o_dat, o_lst, acc;
    int   stall_viol;
    logic timed_out;

    task automatic model_accept(input logic b, input logic l);
        if (!m_open) begin
            m_ci   = coding_indicator;
            m_open = 1'b1;
        end
        if (m_ci == CI_S8) begin
            exp_q.push_back({b, 1'b0});
            exp_q.push_back({b, 1'b0});
            exp_q.push_back({~b, 1'b0});
            exp_q.push_back({~b, l});
        end else begin
            exp_q.push_back({b, l});
        end
        if (l) m_open = 1'b0;
    endtask

    // Drive one cycle at the falling edge, sample just after, update the model.
    task automatic cyc(input logic tv, input logic td, input logic tl, input logic ordy,
                       input logic rs, input logic bp, input ble_ci_t ci);
        @(negedge aclk);
        input_tvalid     = tv;
        input_tdata      = td;
        input_tlast      = tl;
        output_tready    = ordy;
        restart          = rs;
        bypass           = bp;
        coding_indicator = ci;
        #1;
        o_rdy = input_tready;
        o_val = output_tvalid;
        o_dat = output_tdata;
        o_lst = output_tlast;
        acc   = tv && o_rdy && !bp && !rs;
        if (acc) model_accept(td, tl);
        if (rs) begin
            exp_q.delete();
            m_open = 1'b0;
        end
    endtask

    // Streams the fb/fl/fc feed, collecting transferred chips; no comparisons here.
    task automatic pump(input int rdy_pct, input int tv_pct, input int max_cyc);
        logic    ps, pd, pl, tv, ordy;
        ble_ci_t ci;
        int      c;
        ps = 1'b0; pd = 1'b0; pl = 1'b0; ci = CI_S8; c = 0;
        got_q.delete();
        got_cyc.delete();
        rdy_log.delete();
        stall_viol = 0;
        timed_out  = 1'b0;
        while (1) begin
            if (c > 0 && fb.size() == 0 && !o_val) break;
            if (c >= max_cyc) begin
                timed_out = 1'b1;
                break;
            end
            tv   = (fb.size() > 0) && ($urandom_range(0, 99) < tv_pct);
            ordy = $urandom_range(0, 99) < rdy_pct;
            if (fc.size() > 0) ci = fc[0];
            cyc(tv, tv ? fb[0] : 1'b0, tv ? fl[0] : 1'b0, ordy, 1'b0, 1'b0, ci);
            if (ps && (!o_val || o_dat !== pd || o_lst !== pl)) stall_viol++;
            ps = o_val && !ordy;
            pd = o_dat;
            pl = o_lst;
            rdy_log.push_back(o_rdy);
            if (o_val && ordy) begin
                got_q.push_back({o_dat, o_lst});
                got_cyc.push_back(c);
            end
            if (acc) begin
                void'(fb.pop_front());
                void'(fl.pop_front());
                void'(fc.pop_front());
            end
            c++;
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CI_S8);
        total++;
        if ({o_val, o_dat, o_lst} !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 000", {o_val, o_dat, o_lst});
        end
        total++;
        if (o_rdy !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", o_rdy);
        end
        areset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CI_S8);
        total++;
        if ({o_val, o_lst, o_rdy} !== 3'b001) begin
            bad++;
            $display("FAIL post_reset_idle: got %b want 001", {o_val, o_lst, o_rdy});
        end
    endtask

    task automatic test_s8_no_stall();
        logic [7:0] gd, gl;
        int         rc;
        gd = '0; gl = '0; rc = 0;
        fb = '{1'b0, 1'b1};
        fl = '{1'b0, 1'b1};
        fc = '{CI_S8, CI_S8};
        pump(100, 100, 40);
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            gd[7-i] = got_q[i][1];
            gl[7-i] = got_q[i][0];
        end
        for (int i = 1; i <= 8 && i < rdy_log.size(); i++) rc += int'(rdy_log[i]);
        total++;
        if (timed_out || got_q.size() != 8) begin
            bad++;
            $display("FAIL s8_count: got %0d chips (timeout=%b) want 8", got_q.size(), timed_out);
        end
        total++;
        if (gd !== 8'b00111100 || gl !== 8'b00000001) begin
            bad++;
            $display("FAIL s8_pattern: got data %b last %b want 00111100 00000001", gd, gl);
        end
        total++;
        if (got_cyc.size() != 8 || got_cyc[0] != 1 || got_cyc[7] != 8) begin
            bad++;
            $display("FAIL s8_timing: got %0d chips first/last cycle %0d/%0d want 1/8",
                     got_cyc.size(), got_cyc.size() > 0 ? got_cyc[0] : -1,
                     got_cyc.size() > 0 ? got_cyc[got_cyc.size()-1] : -1);
        end
        total++;
        if (rc != 2) begin
            bad++;
            $display("FAIL s8_ready_duty: got %0d ready cycles in 8 want 2", rc);
        end
        exp_q.delete();
    endtask

    task automatic test_s2_stream();
        logic [3:0] gd, gl;
        gd = '0; gl = '0;
        fb = '{1'b1, 1'b0, 1'b1, 1'b1};
        fl = '{1'b0, 1'b0, 1'b0, 1'b1};
        fc = '{CI_S2, CI_S2, CI_S2, CI_S2};
        pump(100, 100, 40);
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            gd[3-i] = got_q[i][1];
            gl[3-i] = got_q[i][0];
        end
        total++;
        if (timed_out || gd !== 4'b1011 || gl !== 4'b0001 || got_q.size() != 4) begin
            bad++;
            $display("FAIL s2_pattern: got %0d chips data %b last %b want 4 1011 0001",
                     got_q.size(), gd, gl);
        end
        total++;
        if (got_cyc.size() != 4 || got_cyc[0] != 1 || got_cyc[3] != 4) begin
            bad++;
            $display("FAIL s2_timing: got %0d chips, want one per cycle on cycles 1..4",
                     got_cyc.size());
        end
        exp_q.delete();
    endtask

    task automatic test_random_stalls();
        logic [7:0] byte_v;
        byte_v = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            fb.push_back(byte_v[i]);
            fl.push_back(i == 7);
            fc.push_back(CI_S8);
        end
        pump(50, 100, 400);
        total++;
        if (timed_out || got_q.size() != 32 || exp_q.size() != 32) begin
            bad++;
            $display("FAIL stall_count: got %0d chips model %0d (timeout=%b) want 32",
                     got_q.size(), exp_q.size(), timed_out);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL stall_chip[%0d]: got %b want %b", i, got_q[i], exp_q[i]);
            end
        end
        total++;
        if (stall_viol != 0) begin
            bad++;
            $display("FAIL stall_hold: got %0d unstable stalled cycles want 0", stall_viol);
        end
        exp_q.delete();
    endtask

    task automatic test_indicator_switch();
        fb = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        fl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        fc = '{CI_S8, CI_S2, CI_S2, CI_S2, CI_S2};
        pump(80, 100, 200);
        total++;
        if (timed_out || got_q.size() != 14) begin
            bad++;
            $display("FAIL ci_switch_count: got %0d chips want 14", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL ci_switch_chip[%0d]: got %b want %b", i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_restart_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, CI_S8);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CI_S8);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CI_S8);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CI_S8);
        total++;
        if (o_rdy !== 1'b0) begin
            bad++;
            $display("FAIL restart_ready: got %b want 0", o_rdy);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CI_S8);
        total++;
        if ({o_val, o_dat, o_lst} !== 3'b000) begin
            bad++;
            $display("FAIL restart_flush: got %b want 000", {o_val, o_dat, o_lst});
        end
        for (int i = 0; i < 3; i++) begin
            fb.push_back(1'($urandom_range(0, 1)));
            fl.push_back(i == 2);
            fc.push_back(CI_S8);
        end
        pump(70, 100, 200);
        total++;
        if (timed_out || got_q.size() != 12 || exp_q.size() != 12) begin
            bad++;
            $display("FAIL restart_fresh_count: got %0d model %0d want 12",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL restart_fresh_chip[%0d]: got %b want %b", i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        // Asynchronous reset in the middle of a clock phase.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, CI_S8);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CI_S8);
        #2;
        areset = 1'b1;
        #1;
        total++;
        if ({output_tvalid, output_tdata, output_tlast, input_tready} !== 4'b0001) begin
            bad++;
            $display("FAIL areset_async: got %b want 0001",
                     {output_tvalid, output_tdata, output_tlast, input_tready});
        end
        @(negedge aclk);
        areset = 1'b0;
        exp_q.delete();
        m_open = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fb.push_back(1'($urandom_range(0, 1)));
            fl.push_back(i == 3);
            fc.push_back(CI_S2);
        end
        pump(70, 100, 200);
        total++;
        if (timed_out || got_q.size() != 4 || exp_q.size() != 4) begin
            bad++;
            $display("FAIL areset_fresh_count: got %0d model %0d want 4",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL areset_fresh_chip[%0d]: got %b want %b", i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_bypass();
        logic tv, td, tl, ordy;
        for (int i = 0; i < 20; i++) begin
            tv   = 1'($urandom_range(0, 1));
            td   = 1'($urandom_range(0, 1));
            tl   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            cyc(tv, td, tl, ordy, 1'b0, 1'b1, CI_S8);
            total++;
            if ({o_dat, o_val, o_lst, o_rdy} !== {td, tv, tl, ordy}) begin
                bad++;
                $display("FAIL bypass[%0d]: got %b want %b", i,
                         {o_dat, o_val, o_lst, o_rdy}, {td, tv, tl, ordy});
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CI_S8);
        total++;
        if ({o_val, o_rdy} !== 2'b01) begin
            bad++;
            $display("FAIL bypass_state_held: got %b want 01", {o_val, o_rdy});
        end
    endtask

    task automatic test_back_to_back();
        for (int run = 0; run < 2; run++) begin
            for (int p = 0; p < 6; p++) begin
                int len;
                len = $urandom_range(1, 5);
                for (int i = 0; i < len; i++) begin
                    fb.push_back(1'($urandom_range(0, 1)));
                    fl.push_back(i == len - 1);
                    // Per-bit random indicator: only the first bit of a packet should matter.
                    fc.push_back($urandom_range(0, 1) ? CI_S2 : CI_S8);
                end
            end
            pump(run == 0 ? 100 : 60, run == 0 ? 100 : 80, 2000);
            total++;
            if (timed_out || got_q.size() != exp_q.size()) begin
                bad++;
                $display("FAIL b2b_count[%0d]: got %0d chips model %0d (timeout=%b)",
                         run, got_q.size(), exp_q.size(), timed_out);
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL b2b_chip[%0d][%0d]: got %b want %b",
                             run, i, got_q[i], exp_q[i]);
                end
            end
            total++;
            if (stall_viol != 0) begin
                bad++;
                $display("FAIL b2b_stall_hold[%0d]: got %0d want 0", run, stall_viol);
            end
            exp_q.delete();
        end
    endtask

    initial begin
        areset           = 1'b1;
        restart          = 1'b0;
        bypass           = 1'b0;
        coding_indicator = CI_S8;
        input_tdata      = 1'b0;
        input_tvalid     = 1'b0;
        input_tlast      = 1'b0;
        output_tready    = 1'b0;
        o_val            = 1'b0;
        test_reset();
        test_s8_no_stall();
        test_s2_stream();
        test_random_stalls();
        test_indicator_switch();
        test_restart_reset();
        test_bypass();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
